i2c_config_sequencer: RTL and testbench
=======================================

Name: i2c_config_sequencer

Overview:
Drives i2c_controller through a fixed power-up configuration of the audio codec. Reads configuration bytes from an external ROM and issues one WRITE transaction per entry to a fixed peripheral address, with a settle gap between transactions. Optionally finishes with one READ transaction whose result is compared against an expected ID byte. Sits between top-level reset/start logic and the single i2c_controller instance.

Parameters:
NUM_ENTRIES, 8, number of ROM bytes to transmit (0 allowed)
ADDR_W, 4, rom_addr width; requires 2**ADDR_W >= NUM_ENTRIES
PERIPH_ADDR, 7'd5, 7-bit peripheral address for every transaction
GAP_CYCLES, 16, idle clk cycles between completion of one transaction and start of the next (>=1)
TIMEOUT_CYCLES, 1024, max cycles allowed in each ISSUE or BUSY phase
VERIFY, 1, 1 = perform the final ID read and compare; 0 = skip it
EXPECT_ID, 8'hB5, expected read_byte of the verify read

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level; sampled in IDLE/DONE/ERROR to begin a run
rom_addr  output  ADDR_W  index of current entry
rom_data  input  8  combinational ROM output for rom_addr
i2c_enable  output  1  transaction request to i2c_controller
i2c_mode  output  1  0 = READ, 1 = WRITE
i2c_periph_addr  output  7  always PERIPH_ADDR
i2c_transmit_byte  output  8  byte for current WRITE
i2c_ready  input  1  1 = controller idle
i2c_read_byte  input  8  controller read result
busy  output  1  run in progress
done  output  1  run completed and verified
error  output  1  timeout or ID mismatch
id_byte  output  8  captured verify-read byte

Behaviour:
- Reset (async): state IDLE, rom_addr=0, i2c_enable=0, i2c_mode=0, i2c_transmit_byte=0, busy=0, done=0, error=0, id_byte=0, counters 0. Reset mid-run aborts immediately; i2c_enable drops asynchronously. i2c_periph_addr is constant.
- States: IDLE, LOAD, ISSUE, BUSY, GAP, VERIFY, CHECK, DONE, ERROR.
- IDLE/DONE/ERROR + start=1: next cycle rom_addr=0, busy=1, done=0, error=0; go to LOAD; if NUM_ENTRIES==0, go to VERIFY (VERIFY=1) or DONE (VERIFY=0).
- start while busy=1: ignored.
- LOAD (1 cycle): latch rom_data into i2c_transmit_byte, i2c_mode=1, go to ISSUE.
- ISSUE: timeout counter starts at 0. While i2c_ready=0, keep i2c_enable=0 (controller still busy). Once i2c_ready=1, register i2c_enable=1. Hold enable until i2c_ready=0 is sampled with enable high (accept). Then deassert enable the next cycle and go to BUSY.
- BUSY: counter restarts; wait for i2c_ready=1, then go to GAP.
- Timeout in ISSUE or BUSY: counter reaches TIMEOUT_CYCLES -> ERROR; i2c_enable=0.
- GAP: count GAP_CYCLES cycles.
  - If rom_addr==NUM_ENTRIES-1 -> VERIFY (VERIFY=1) or DONE (VERIFY=0).
  - Otherwise rom_addr+1 -> LOAD. rom_addr never exceeds NUM_ENTRIES-1.
- VERIFY: i2c_mode=0, then the same ISSUE/BUSY handshake and timeout rules. On ready return, go to CHECK.
- CHECK (1 cycle): id_byte<=i2c_read_byte. Equal to EXPECT_ID -> DONE, else ERROR.
- DONE: done=1, busy=0, held until next start or reset.
- ERROR: error=1, busy=0, held; start retries from entry 0.
- done and error are never both 1.
- Outputs are registered; no combinational path from i2c_ready to i2c_enable.

Test Plan:
- Bench uses a behavioural controller model: ready drops 2 cycles after enable, returns 20 cycles later, read_byte programmable.
- Reset check: assert reset mid-cycle -> all outputs read 0 immediately, i2c_periph_addr=5.
- Nominal run: NUM_ENTRIES=3, ROM {8'h1E,8'h00,8'h12}, model read_byte=8'hB5, pulse start.
  - Required: three WRITEs with transmit_byte 1E,00,12 in order; mode=1 and addr=5 at each enable.
  - Required: >=16 idle cycles between consecutive transactions.
  - Required: then one READ (mode=0), followed by done=1, id_byte=B5, busy=0, error=0.
- Mismatch: model read_byte=8'h00 -> error=1, done=0, id_byte=00 after CHECK.
- Timeout: model never drops ready after enable -> error=1 exactly TIMEOUT_CYCLES after ISSUE entry, i2c_enable=0, no further transactions.
- Start rules:
  - start held during run -> no restart; rom_addr sequence unchanged.
  - start after DONE -> new run beginning at rom_addr=0, done cleared next cycle.
- Abort: reset asserted during BUSY of entry 1 -> enable/busy 0 immediately. After release + start, the sequence restarts at entry 0 and completes.

Source files
------------

// File: rtl/i2c_config_sequencer.sv
// Power-up configuration sequencer for the audio codec: streams ROM bytes as I2C
// WRITEs to one peripheral, then optionally reads back and checks an ID byte.
module i2c_config_sequencer #(
  parameter int         NUM_ENTRIES    = 8,
  parameter int         ADDR_W         = 4,
  parameter logic [6:0] PERIPH_ADDR    = 7'd5,
  parameter int         GAP_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter bit         VERIFY         = 1'b1,
  parameter logic [7:0] EXPECT_ID      = 8'hB5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              i2c_enable,
  output logic              i2c_mode,
  output logic [6:0]        i2c_periph_addr,
  output logic [7:0]        i2c_transmit_byte,
  input  logic              i2c_ready,
  input  logic [7:0]        i2c_read_byte,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        id_byte
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_ISSUE  = 4'd2;
  localparam logic [3:0] S_BUSY   = 4'd3;
  localparam logic [3:0] S_GAP    = 4'd4;
  localparam logic [3:0] S_VERIFY = 4'd5;
  localparam logic [3:0] S_CHECK  = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERROR  = 4'd8;

  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((NUM_ENTRIES > 0) ? NUM_ENTRIES - 1 : 0);
  localparam logic [3:0] S_AFTER_WRITES = VERIFY ? S_VERIFY : S_DONE;
  localparam logic [3:0] S_AFTER_START  = (NUM_ENTRIES > 0) ? S_LOAD : S_AFTER_WRITES;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              enable_q, enable_d;
  logic              mode_q, mode_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        id_byte_q, id_byte_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    enable_d   = enable_q;
    mode_d     = mode_q;
    tx_byte_d  = tx_byte_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    id_byte_d  = id_byte_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          rom_addr_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          cnt_d      = '0;
          state_d    = S_AFTER_START;
          if (S_AFTER_START == S_DONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        tx_byte_d = rom_data;
        mode_d    = 1'b1;
        cnt_d     = '0;
        state_d   = S_ISSUE;
      end
      S_VERIFY: begin
        mode_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        // ready low while we hold enable means the controller took the request
        if (enable_q && !i2c_ready) begin
          enable_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end else if (cnt_q == TO_LAST) begin
          enable_d = 1'b0;
          busy_d   = 1'b0;
          error_d  = 1'b1;
          state_d  = S_ERROR;
        end else if (i2c_ready) begin
          enable_d = 1'b1;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (i2c_ready) begin
          cnt_d   = '0;
          state_d = mode_q ? S_GAP : S_CHECK;
        end else if (cnt_q == TO_LAST) begin
          busy_d  = 1'b0;
          error_d = 1'b1;
          state_d = S_ERROR;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (rom_addr_q == LAST_ADDR) begin
            state_d = S_AFTER_WRITES;
            if (S_AFTER_WRITES == S_DONE) begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end
          end else begin
            rom_addr_d = rom_addr_q + 1'b1;
            state_d    = S_LOAD;
          end
        end
      end
      S_CHECK: begin
        id_byte_d = i2c_read_byte;
        busy_d    = 1'b0;
        if (i2c_read_byte == EXPECT_ID) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      enable_q   <= 1'b0;
      mode_q     <= 1'b0;
      tx_byte_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      id_byte_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      id_byte_q  <= id_byte_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rom_addr          = rom_addr_q;
  assign i2c_enable        = enable_q;
  assign i2c_mode          = mode_q;
  assign i2c_periph_addr   = PERIPH_ADDR;
  assign i2c_transmit_byte = tx_byte_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign id_byte           = id_byte_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer: behavioural I2C controller plus a transaction-list
// reference built from the ROM contents and the expected-ID rule.
module tb_i2c_config_sequencer;
  localparam int TO  = 64;
  localparam int GAP = 16;
  localparam int NE  = 3;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data, i2c_transmit_byte, i2c_read_byte, id_byte;
  logic       i2c_enable, i2c_mode, i2c_ready, busy, done, error;
  logic [6:0] i2c_periph_addr;

  i2c_config_sequencer #(
    .NUM_ENTRIES(NE), .ADDR_W(4), .PERIPH_ADDR(7'd5), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TO), .VERIFY(1'b1), .EXPECT_ID(8'hB5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_enable(i2c_enable), .i2c_mode(i2c_mode), .i2c_periph_addr(i2c_periph_addr),
    .i2c_transmit_byte(i2c_transmit_byte), .i2c_ready(i2c_ready),
    .i2c_read_byte(i2c_read_byte), .busy(busy), .done(done), .error(error), .id_byte(id_byte)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:3];
  assign rom_data = (rom_addr < 4'd3) ? rom[rom_addr[1:0]] : 8'hEE;

  logic [7:0] rb;
  bit         hang;
  logic       rdy;
  assign i2c_ready     = rdy;
  assign i2c_read_byte = rb;

  typedef struct {
    logic       mode;
    logic [6:0] pa;
    logic [7:0] tx;
    logic [3:0] ra;
    int         s;
    int         e;
  } txn_t;
  txn_t log_q[$];
  txn_t nt;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: ready drops 2 cycles after enable, returns ~20 cycles later
  int   phase, mcnt;
  logic en_prev;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy <= 1'b1; phase <= 0; mcnt <= 0; en_prev <= 1'b0;
    end else begin
      en_prev <= i2c_enable;
      if (i2c_enable && !en_prev) begin
        nt.mode = i2c_mode; nt.pa = i2c_periph_addr; nt.tx = i2c_transmit_byte;
        nt.ra = rom_addr; nt.s = cyc; nt.e = -1;
        log_q.push_back(nt);
      end
      case (phase)
        0: if (i2c_enable && rdy && !hang) phase <= 1;
        1: begin rdy <= 1'b0; phase <= 2; mcnt <= 19; end
        default: begin
          if (mcnt == 0) begin
            rdy <= 1'b1; phase <= 0;
            if (log_q.size() > 0) log_q[log_q.size()-1].e = cyc;
          end else mcnt <= mcnt - 1;
        end
      endcase
    end
  end

  bit both_hi = 1'b0, oob = 1'b0;
  always @(negedge clk) begin
    if (done && error) both_hi <= 1'b1;
    if (rom_addr > 4'd2) oob <= 1'b1;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},    32'(i2c_enable), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_err"},   32'(error), 0);
    chk({tag, "_addr"},  32'(rom_addr), 0);
    chk({tag, "_mode"},  32'(i2c_mode), 0);
    chk({tag, "_tx"},    32'(i2c_transmit_byte), 0);
    chk({tag, "_id"},    32'(id_byte), 0);
    chk({tag, "_paddr"}, 32'(i2c_periph_addr), 5);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (done || error) break;
    end
    chk("end_bound", 32'(done || error), 1);
  endtask

  // Reference: NE writes of rom[i] in order, one read, then done iff rb matches
  task automatic check_run(input string tag, input logic [7:0] rbv);
    int n;
    bit ok;
    ok = (rbv == 8'hB5);
    n  = log_q.size();
    chk({tag, "_ntxn"}, 32'(n), NE + 1);
    for (int i = 0; i < n && i <= NE; i++) begin
      chk({tag, "_paddr"}, 32'(log_q[i].pa), 5);
      if (i < NE) begin
        chk({tag, "_wmode"}, 32'(log_q[i].mode), 1);
        chk({tag, "_wbyte"}, 32'(log_q[i].tx), 32'(rom[i]));
        chk({tag, "_waddr"}, 32'(log_q[i].ra), 32'(i));
      end else begin
        chk({tag, "_rmode"}, 32'(log_q[i].mode), 0);
      end
      if (i > 0) chk({tag, "_gap"}, 32'((log_q[i].s - log_q[i-1].e - 1) >= GAP), 1);
    end
    chk({tag, "_done"}, 32'(done), 32'(ok));
    chk({tag, "_err"},  32'(error), 32'(!ok));
    chk({tag, "_id"},   32'(id_byte), 32'(rbv));
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int en_at, err_at, n0;
    rb = 8'hB5; hang = 1'b0;
    rom[0] = 8'h1E; rom[1] = 8'h00; rom[2] = 8'h12; rom[3] = 8'h00;
    #12 chk_reset_outputs("rst0");
    @(negedge clk) reset = 1'b0;

    // nominal
    log_q.delete(); pulse_start(); wait_end(2000); check_run("nom", rb);

    // start from DONE clears done next cycle and restarts at entry 0
    log_q.delete();
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    chk("restart_done", 32'(done), 0);
    chk("restart_busy", 32'(busy), 1);
    chk("restart_addr", 32'(rom_addr), 0);
    start = 1'b0;
    wait_end(2000); check_run("rerun", rb);

    // ID mismatch
    rb = 8'h00; log_q.delete(); pulse_start(); wait_end(2000); check_run("mism", rb);

    // randomized ROM / read byte
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NE; i++) rom[i] = 8'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? 8'hB5 : 8'($urandom_range(0, 255));
      log_q.delete(); pulse_start(); wait_end(2000); check_run("rand", rb);
    end

    // start held through the run is ignored while busy
    rb = 8'hB5; log_q.delete();
    @(negedge clk) start = 1'b1;
    for (int n = 0; n < 2000 && log_q.size() < NE + 1; n++) @(negedge clk);
    start = 1'b0;
    wait_end(2000); check_run("held", rb);

    // timeout: controller never accepts
    hang = 1'b1; log_q.delete(); en_at = -1; err_at = -1;
    pulse_start();
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (i2c_enable && en_at < 0) en_at = cyc;
      if (error) begin err_at = cyc; break; end
    end
    chk("to_err", 32'(error), 1);
    chk("to_lat", 32'(err_at - en_at), TO - 1);
    chk("to_en", 32'(i2c_enable), 0);
    chk("to_done", 32'(done), 0);
    n0 = log_q.size();
    repeat (100) @(negedge clk);
    chk("to_ntxn", 32'(n0), 1);
    chk("to_quiet", 32'(log_q.size()), 1);
    chk("to_hold", 32'(error), 1);
    hang = 1'b0;

    // abort during BUSY of entry 1, then a clean rerun
    log_q.delete(); pulse_start();
    for (int n = 0; n < 2000 && !(log_q.size() >= 2 && rdy == 1'b0); n++) @(negedge clk);
    chk("abort_reached", 32'(log_q.size()), 2);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("abort");
    @(negedge clk) reset = 1'b0;
    log_q.delete(); pulse_start(); wait_end(2000); check_run("post", rb);

    chk("never_both", 32'(both_hi), 0);
    chk("addr_range", 32'(oob), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
